team_06_pwm_audio_out: RTL and testbench

TEAM_06_PWM_AUDIO_OUT -- requirements
Module: team_06_pwm_audio_out

---
 rtl/team_06_pwm_audio_out.sv | 101 ++++++++++
 tb/tb_team_06_pwm_audio_out.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/team_06_pwm_audio_out.sv
// PWM audio out: 8-bit period counter, one-entry sample buffer loaded at each period boundary, sticky underrun; pwm_out lags cnt by one clock.
// sample_ready drops while a sample is pending and reopens after the boundary load; define TEAM_06_PWM_PRESCALE_EN to tick every PRESCALE clocks.
module team_06_pwm_audio_out #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] audio_in,
    input  logic       sample_valid,
    output logic       sample_ready,
    output logic       sample_req,
    input  logic       clear_underrun,
    output logic       underrun,
    output logic       pwm_out
);

    if (PRESCALE < 2) begin : g_prescale_check
        $error("PRESCALE must be at least 2");
    end

    logic [7:0] cnt;
    logic [7:0] duty;
    logic [7:0] pending;
    logic       full;
    logic       tick;
    logic       boundary;
    logic       accept;

`ifdef TEAM_06_PWM_PRESCALE_EN
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (!enable || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign boundary     = enable && tick && (cnt == 8'd255);
    assign sample_req   = boundary;
    assign sample_ready = !full;
    assign accept       = sample_valid && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (!enable) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= cnt + 8'd1;
        end
    end

    // A full buffer cannot accept, so the boundary load and a new accept never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty    <= 8'd0;
            pending <= 8'd0;
            full    <= 1'b0;
        end else begin
            if (boundary && full) begin
                duty <= pending;
                full <= 1'b0;
            end else if (accept) begin
                pending <= audio_in;
                full    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (boundary && !full) begin
            underrun <= 1'b1;
        end else if (clear_underrun) begin
            underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= enable && (cnt < duty);
        end
    end

endmodule

// File: tb/tb_team_06_pwm_audio_out.sv
// Randomized and directed bench for team_06_pwm_audio_out against a period-level reference model.
module tb_team_06_pwm_audio_out;
`ifdef TEAM_06_PWM_PRESCALE_EN
    localparam int TPC = 4;
`else
    localparam int TPC = 1;
`endif
    localparam int PER = 256 * TPC;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] audio_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       sample_req;
    logic       clear_underrun;
    logic       underrun;
    logic       pwm_out;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic       last_req;
    logic [7:0] offers[$];
    int         acc_at[$];

    // Reference model: position within the period, duty, one-deep pending queue, flags.
    int         pos;
    int         ps;
    int         duty_m;
    logic [7:0] q[$];
    logic       ur_m;
    logic       pwm_m;

    team_06_pwm_audio_out #(.PRESCALE(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .audio_in       (audio_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .sample_req     (sample_req),
        .clear_underrun (clear_underrun),
        .underrun       (underrun),
        .pwm_out        (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pos    = 0;
        ps     = 0;
        duty_m = 0;
        q.delete();
        ur_m   = 1'b0;
        pwm_m  = 1'b0;
    endtask

    // One clock: drive inputs, check combinational outputs, clock, then check registered outputs.
    task automatic step(input logic en_i, input logic clr_i, input logic rst_i);
        logic       tk;
        logic       bnd;
        logic       acc;
        logic [7:0] din;
        enable         = en_i;
        clear_underrun = clr_i;
        rst            = rst_i;
        sample_valid   = (offers.size() > 0);
        din            = sample_valid ? offers[0] : 8'($urandom);
        audio_in       = din;
        if (rst_i) model_reset();
        #2;
        tk  = (ps == TPC - 1);
        bnd = !rst_i && en_i && tk && (pos == 255);
        acc = !rst_i && sample_valid && (q.size() == 0);
        last_req = sample_req;
        check("req", sample_req, bnd);
        check("ready", sample_ready, q.size() == 0);
        if (acc) begin
            void'(offers.pop_front());
            acc_at.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_i) begin
            pwm_m = en_i && (pos < duty_m);
            if (bnd) begin
                if (q.size() > 0) duty_m = q.pop_front();
                else              ur_m   = 1'b1;
            end else if (clr_i) begin
                ur_m = 1'b0;
            end
            if (acc) q.push_back(din);
            if (!en_i) begin
                pos = 0;
                ps  = 0;
            end else if (tk) begin
                pos = (pos + 1) % 256;
                ps  = 0;
            end else begin
                ps++;
            end
        end
        check("pwm", pwm_out, pwm_m);
        check("underrun", underrun, ur_m);
    endtask

    // Runs one full period starting at cnt=0 and checks its high count and single boundary request.
    task automatic run_period(input int exp_hi, input int clr_idx, input logic clr_exp, input string tag);
        int hi   = 0;
        int reqs = 0;
        for (int i = 0; i < PER; i++) begin
            step(1'b1, i == clr_idx, 1'b0);
            hi   += int'(pwm_out);
            reqs += int'(last_req);
            if (i == clr_idx) check({tag, "_clr"}, underrun, clr_exp);
        end
        check({tag, "_hi"}, hi, exp_hi * TPC);
        check({tag, "_reqs"}, reqs, 1);
        check({tag, "_req_last"}, last_req, 1);
    endtask

    initial begin
        int c0;
        rst            = 1'b1;
        enable         = 1'b1;
        sample_valid   = 1'b0;
        audio_in       = 8'd0;
        clear_underrun = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        check("rst_pwm", pwm_out, 0);
        check("rst_ready", sample_ready, 1);
        check("rst_underrun", underrun, 0);
        check("rst_req", sample_req, 0);

        offers.push_back(8'd64);
        run_period(0, -1, 1'b0, "p0_initial");
        offers.push_back(8'd64);
        run_period(64, -1, 1'b0, "p1_duty64");
        check("p1_no_underrun", underrun, 0);
        offers.push_back(8'd0);
        run_period(64, -1, 1'b0, "p2_duty64");
        offers.push_back(8'd255);
        run_period(0, -1, 1'b0, "p3_duty0");
        offers.push_back(8'd128);
        run_period(255, -1, 1'b0, "p4_duty255");
        run_period(128, -1, 1'b0, "p5_duty128");
        check("ur_set", underrun, 1);
        run_period(128, 10, 1'b0, "p6_repeat");
        check("ur_set_again", underrun, 1);
        run_period(128, PER - 1, 1'b1, "p7_clr_on_bnd");

        offers.push_back(8'd10);
        offers.push_back(8'd20);
        c0 = cyc;
        run_period(128, -1, 1'b0, "p8_backpressure");
        run_period(10, -1, 1'b0, "p9_duty10");
        check("bp_10_accept_at", acc_at[acc_at.size() - 2] - c0, 0);
        check("bp_20_accept_at", acc_at[acc_at.size() - 1] - c0, PER);
        run_period(20, -1, 1'b0, "p10_duty20");

        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        check("pre_drop_pwm", pwm_out, 1);
        step(1'b0, 1'b0, 1'b0);
        check("drop_pwm", pwm_out, 0);
        step(1'b0, 1'b0, 1'b0);
        run_period(20, -1, 1'b0, "reenable_duty20");

        for (int i = 0; i < 3000; i++) begin
            if (offers.size() == 0 && $urandom_range(0, 99) < 40) offers.push_back(8'($urandom));
            step($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 5);
        end

        offers.delete();
        offers.push_back(8'd200);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("arst_pwm", pwm_out, 0);
        check("arst_ready", sample_ready, 1);
        check("arst_underrun", underrun, 0);
        check("arst_req", sample_req, 0);
        model_reset();
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
